// File: rtl/running_pkg.sv
// Shared types and helpers for the running-sum pipeline stages.
package running_pkg;

    // Largest supported log2 window depth.
    localparam int MAX_WIN_LOG2 = 6;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Window depth in beats for a given log2 depth.
    function automatic int win_depth(input int log2);
        return 1 << log2;
    endfunction

endpackage

// File: rtl/running_ring_buf.sv
// Ring buffer of past cumulative sums for running_window_sum.
// Read is combinational at wr_ptr so the oldest entry is seen before it is overwritten.
module running_ring_buf #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_ptr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next-state of the storage: hold everything, overwrite one slot on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = wr_data;
        end
    end

    // Storage registers.
    // NOTE: this array is small and held in flops, so it is reset explicitly; a
    // RAM-mapped memory would not be, and its contents would be undefined after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[wr_ptr];

endmodule

// File: rtl/running_window_sum.sv
// Sliding-window sum over the last 2**WIN_LOG2 beats of a cumulative sum stream,
// computed as newest sum minus the sum seen WIN_DEPTH beats earlier (modulo 2**in_width).
// Optional feature: define RUNNING_WINDOW_AVG_OUT_EN to add the avg_out port
// (window sum >> WIN_LOG2, registered alongside win_out).
module running_window_sum
    import running_pkg::*;
#(
    parameter int in_width = 16,
    parameter int WIN_LOG2 = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sum_in_valid,
    input  logic [in_width-1:0]          sum_in,
    output logic                         win_out_valid,
    output logic [in_width-1:0]          win_out,
`ifdef RUNNING_WINDOW_AVG_OUT_EN
    output logic [in_width-WIN_LOG2-1:0] avg_out,
`endif
    output logic                         fill_done
);

    localparam int WIN_DEPTH = win_depth(WIN_LOG2);
    localparam logic [WIN_LOG2-1:0] LAST_FILL = WIN_LOG2'(WIN_DEPTH - 1);

    // Reject window depths outside the supported range at elaboration time.
    if (WIN_LOG2 < 1 || WIN_LOG2 > MAX_WIN_LOG2) begin : g_bad_win_log2
        $error("running_window_sum: WIN_LOG2 out of range");
    end

    state_e                state_q, state_d;
    logic [WIN_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [WIN_LOG2-1:0]   fill_cnt_q, fill_cnt_d;
    logic [in_width-1:0]   win_out_q, win_out_d;
    logic                  win_out_valid_q, win_out_valid_d;
    logic [in_width-1:0]   oldest_sum;

    // Oldest cumulative sum lives at wr_ptr; every beat overwrites it with the newest.
    running_ring_buf #(
        .WIDTH      (in_width),
        .DEPTH_LOG2 (WIN_LOG2)
    ) u_ring_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sum_in_valid),
        .wr_ptr  (wr_ptr_q),
        .wr_data (sum_in),
        .rd_data (oldest_sum)
    );

    // FSM next state, pointer/counter advance and window subtraction.
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        fill_cnt_d      = fill_cnt_q;
        win_out_d       = win_out_q;
        win_out_valid_d = 1'b0;

        if (sum_in_valid) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            unique case (state_q)
                FILL: begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == LAST_FILL) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    win_out_d       = sum_in - oldest_sum;
                    win_out_valid_d = 1'b1;
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // their inputs from the same edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= FILL;
            wr_ptr_q        <= '0;
            fill_cnt_q      <= '0;
            win_out_q       <= '0;
            win_out_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            fill_cnt_q      <= fill_cnt_d;
            win_out_q       <= win_out_d;
            win_out_valid_q <= win_out_valid_d;
        end
    end

    assign win_out       = win_out_q;
    assign win_out_valid = win_out_valid_q;
    assign fill_done     = (state_q == RUN);

`ifdef RUNNING_WINDOW_AVG_OUT_EN
    logic [in_width-WIN_LOG2-1:0] avg_q, avg_d;

    // Truncating mean, tracking win_out_d so it updates on exactly the same beats.
    always_comb begin
        avg_d = win_out_d[in_width-1:WIN_LOG2];
    end

    // Average register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_q <= '0;
        end else begin
            avg_q <= avg_d;
        end
    end

    assign avg_out = avg_q;
`endif

endmodule

// File: tb/tb_running_window_sum.sv
// Self-checking bench for running_window_sum: directed tests on a WIN_LOG2=2 instance,
// random soak on a WIN_LOG2=3 instance against a sliding-window reference model.
// Define RUNNING_WINDOW_AVG_OUT_EN to also check avg_out.
module tb_running_window_sum;

    logic clk = 1'b0;
    logic rst;

    // WIN_LOG2 = 2 instance (directed tests)
    logic        v2;
    logic [15:0] s2;
    logic        w2_valid;
    logic [15:0] w2;
    logic        f2;

    // WIN_LOG2 = 3 instance (random soak)
    logic        v3;
    logic [15:0] s3;
    logic        w3_valid;
    logic [15:0] w3;
    logic        f3;

`ifdef RUNNING_WINDOW_AVG_OUT_EN
    logic [13:0] a2;
    logic [12:0] a3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    running_window_sum #(.in_width(16), .WIN_LOG2(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .sum_in_valid  (v2),
        .sum_in        (s2),
        .win_out_valid (w2_valid),
        .win_out       (w2),
`ifdef RUNNING_WINDOW_AVG_OUT_EN
        .avg_out       (a2),
`endif
        .fill_done     (f2)
    );

    running_window_sum #(.in_width(16), .WIN_LOG2(3)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .sum_in_valid  (v3),
        .sum_in        (s3),
        .win_out_valid (w3_valid),
        .win_out       (w3),
`ifdef RUNNING_WINDOW_AVG_OUT_EN
        .avg_out       (a3),
`endif
        .fill_done     (f3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of input to the WIN_LOG2=2 instance.
    task automatic step2(input logic v, input logic [15:0] s);
        v2 = v;
        s2 = s;
        tick();
    endtask

    // Reference model state for the soak: increments of the last beats since reset.
    int unsigned incs[$];
    int unsigned n_beats;
    logic [15:0] exp_win;

    function automatic logic [15:0] window_total();
        int unsigned t = 0;
        foreach (incs[i]) t += incs[i];
        return 16'(t);
    endfunction

    initial begin
        logic [15:0] fill_sums [4];
        logic [15:0] cum;
        fill_sums[0] = 16'd1;
        fill_sums[1] = 16'd3;
        fill_sums[2] = 16'd6;
        fill_sums[3] = 16'd10;

        rst = 1'b1;
        v2 = 1'b0; s2 = '0;
        v3 = 1'b0; s3 = '0;
        tick();
        tick();

        // Reset state
        check("rst_win2",   32'(w2), 32'd0);
        check("rst_valid2", 32'(w2_valid), 32'd0);
        check("rst_fill2",  32'(f2), 32'd0);
        check("rst_win3",   32'(w3), 32'd0);
        check("rst_fill3",  32'(f3), 32'd0);
`ifdef RUNNING_WINDOW_AVG_OUT_EN
        check("rst_avg2",   32'(a2), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Prime: four beats, no output; fill_done only after the fourth
        for (int i = 0; i < 4; i++) begin
            step2(1'b1, fill_sums[i]);
            check("prime_valid", 32'(w2_valid), 32'd0);
            check("prime_fill", 32'(f2), (i == 3) ? 32'd1 : 32'd0);
        end
        step2(1'b1, 16'd15);
        check("first_win",   32'(w2), 32'd14);
        check("first_valid", 32'(w2_valid), 32'd1);

        // Gaps: output holds, valid drops
        for (int i = 0; i < 3; i++) begin
            step2(1'b0, 16'hBEEF);
            check("gap_valid", 32'(w2_valid), 32'd0);
            check("gap_hold", 32'(w2), 32'd14);
        end
        step2(1'b1, 16'd21);
        check("post_gap_win",   32'(w2), 32'd18);
        check("post_gap_valid", 32'(w2_valid), 32'd1);

        // Reset mid-RUN, asserted between edges
        v2 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_win",   32'(w2), 32'd0);
        check("mid_rst_valid", 32'(w2_valid), 32'd0);
        check("mid_rst_fill",  32'(f2), 32'd0);
        rst = 1'b0;

        // Refill with sums straddling the 16-bit wrap; no output during fill
        fill_sums[0] = 16'hFFFE;
        fill_sums[1] = 16'hFFFF;
        fill_sums[2] = 16'h0000;
        fill_sums[3] = 16'h0003;
        for (int i = 0; i < 4; i++) begin
            step2(1'b1, fill_sums[i]);
            check("refill_valid", 32'(w2_valid), 32'd0);
        end
        check("refill_fill", 32'(f2), 32'd1);

        // Wrap: 0x0006 - 0xFFFE = 8
        step2(1'b1, 16'h0006);
        check("wrap_win",   32'(w2), 32'd8);
        check("wrap_valid", 32'(w2_valid), 32'd1);

        // Window sums 40 and 43 (oldest entries 0xFFFF and 0x0000)
        step2(1'b1, 16'h0027);
        check("win40", 32'(w2), 32'd40);
`ifdef RUNNING_WINDOW_AVG_OUT_EN
        check("avg40", 32'(a2), 32'd10);
`endif
        step2(1'b1, 16'h002B);
        check("win43", 32'(w2), 32'd43);
`ifdef RUNNING_WINDOW_AVG_OUT_EN
        check("avg43", 32'(a2), 32'd10);
`endif
        step2(1'b0, 16'h0);

        // Random soak on WIN_LOG2=3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        incs.delete();
        n_beats = 0;
        exp_win = '0;
        cum = 16'($urandom);
        for (int cyc = 0; cyc < 2000 && n_beats < 200; cyc++) begin
            logic        v;
            int unsigned inc;
            v   = ($urandom_range(0, 9) < 7);
            inc = $urandom_range(0, 4000);
            if (v) cum = cum + 16'(inc);
            v3 = v;
            s3 = v ? cum : 16'($urandom);
            tick();
            if (v) begin
                incs.push_back(inc);
                if (incs.size() > 8) void'(incs.pop_front());
                n_beats++;
            end
            if (v && n_beats > 8) begin
                exp_win = window_total();
                check("soak_valid", 32'(w3_valid), 32'd1);
                check("soak_win", 32'(w3), 32'(exp_win));
`ifdef RUNNING_WINDOW_AVG_OUT_EN
                check("soak_avg", 32'(a3), 32'(exp_win >> 3));
`endif
            end else begin
                check("soak_idle_valid", 32'(w3_valid), 32'd0);
                check("soak_hold", 32'(w3), 32'(exp_win));
            end
            check("soak_fill", 32'(f3), (n_beats >= 8) ? 32'd1 : 32'd0);
        end
        check("soak_beats", n_beats, 32'd200);
        v3 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
